// File: rtl/pkt_fifo_sync_pkg.sv
// Shared definitions for the packet FIFO: write-side frame state encodings,
// kept numerically identical to the encodings used by the downstream packet stages.
package pkt_fifo_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_DROP  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/pkt_fifo_sync_dualram.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
// The read data is registered by the instantiating FIFO.
module pkt_fifo_sync_dualram #(
    parameter int AW = 4,
    parameter int DW = 33
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pkt_fifo_sync.sv
// Single-clock packet FIFO with frame commit/abort: only committed frames are
// visible to the reader; partial frames are discarded on abort or overflow.
module pkt_fifo_sync
    import pkt_fifo_sync_pkg::*;
#(
    parameter int ASIZE      = 4,
    parameter int DSIZE      = 32,
    parameter int AFULL_LVL  = 2**ASIZE - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wreq,
    input  logic [DSIZE-1:0] wdata,
    input  logic             wlast,
    input  logic             wabort,
    input  logic             rreq,
    output logic [DSIZE-1:0] rdata,
    output logic             rlast,
    output logic             rvalid,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic             aempty,
    output logic [ASIZE:0]   used,
    output logic [ASIZE:0]   fcount,
    output logic             overflow
);

    localparam logic [ASIZE:0] C_DEPTH  = (ASIZE+1)'(2**ASIZE);
    localparam logic [ASIZE:0] C_AFULL  = (ASIZE+1)'(AFULL_LVL);
    localparam logic [ASIZE:0] C_AEMPTY = (ASIZE+1)'(AEMPTY_LVL);

    wr_state_e        r_state;
    wr_state_e        w_state_next;
    logic [ASIZE:0]   r_waddr;
    logic [ASIZE:0]   r_wcommit;
    logic [ASIZE:0]   r_raddr;
    logic [ASIZE:0]   r_fcount;
    logic [ASIZE:0]   w_waddr_next;
    logic [ASIZE:0]   w_wcommit_next;
    logic [ASIZE:0]   w_used;
    logic [ASIZE:0]   w_committed;
    logic             w_full;
    logic             w_empty;
    logic             w_we;
    logic             w_commit;
    logic             w_ovf;
    logic             w_rd_en;
    logic             w_rd_last;
    logic [DSIZE:0]   w_ram_q;
    logic [DSIZE-1:0] r_rdata;
    logic             r_rlast;
    logic             r_rvalid;
    logic             r_overflow;

    assign w_used      = r_waddr - r_raddr;
    assign w_committed = r_wcommit - r_raddr;
    assign w_full      = (w_used == C_DEPTH);
    assign w_empty     = (r_wcommit == r_raddr);
    assign w_rd_en     = rreq & ~w_empty;
    assign w_rd_last   = w_rd_en & w_ram_q[DSIZE];

    // Write-side frame FSM; abort has priority over everything, including wlast.
    always_comb begin
        w_state_next   = r_state;
        w_waddr_next   = r_waddr;
        w_wcommit_next = r_wcommit;
        w_we           = 1'b0;
        w_commit       = 1'b0;
        w_ovf          = 1'b0;
        if (wabort) begin
            w_waddr_next = r_wcommit;
            w_state_next = ST_IDLE;
        end else if (wreq) begin
            if (r_state == ST_DROP) begin
                if (wlast) begin
                    w_state_next = ST_IDLE;
                end
            end else if (w_full) begin
                w_waddr_next = r_wcommit;
                w_ovf        = 1'b1;
                w_state_next = wlast ? ST_IDLE : ST_DROP;
            end else begin
                w_we         = 1'b1;
                w_waddr_next = r_waddr + 1'b1;
                if (wlast) begin
                    w_wcommit_next = r_waddr + 1'b1;
                    w_commit       = 1'b1;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_state_next = ST_FRAME;
                end
            end
        end
    end

    pkt_fifo_sync_dualram #(
        .AW (ASIZE),
        .DW (DSIZE + 1)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_waddr[ASIZE-1:0]),
        .i_wdata ({wlast, wdata}),
        .i_raddr (r_raddr[ASIZE-1:0]),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_waddr    <= '0;
            r_wcommit  <= '0;
            r_raddr    <= '0;
            r_fcount   <= '0;
            r_rdata    <= '0;
            r_rlast    <= 1'b0;
            r_rvalid   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_waddr    <= w_waddr_next;
            r_wcommit  <= w_wcommit_next;
            r_rvalid   <= w_rd_en;
            r_overflow <= w_ovf;
            if (w_rd_en) begin
                r_rdata <= w_ram_q[DSIZE-1:0];
                r_rlast <= w_ram_q[DSIZE];
                r_raddr <= r_raddr + 1'b1;
            end
            // A commit and a last-beat read in the same cycle cancel out.
            case ({w_commit, w_rd_last})
                2'b10:   r_fcount <= r_fcount + 1'b1;
                2'b01:   r_fcount <= r_fcount - 1'b1;
                default: r_fcount <= r_fcount;
            endcase
        end
    end

    assign rdata    = r_rdata;
    assign rlast    = r_rlast;
    assign rvalid   = r_rvalid;
    assign overflow = r_overflow;
    assign full     = w_full;
    assign empty    = w_empty;
    assign afull    = (w_used >= C_AFULL);
    assign aempty   = (w_committed <= C_AEMPTY);
    assign used     = w_used;
    assign fcount   = r_fcount;

endmodule

// File: tb/tb_pkt_fifo_sync.sv
// Self-checking bench for pkt_fifo_sync (ASIZE=3): queue-based reference model
// with a read scoreboard, a vector table, and hand-written corner sequences.
module tb_pkt_fifo_sync;

    localparam int ASIZE = 3;
    localparam int DSIZE = 32;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wreq = 1'b0;
    logic [DSIZE-1:0] wdata = '0;
    logic             wlast = 1'b0;
    logic             wabort = 1'b0;
    logic             rreq = 1'b0;
    logic [DSIZE-1:0] rdata;
    logic             rlast;
    logic             rvalid;
    logic             full;
    logic             empty;
    logic             afull;
    logic             aempty;
    logic [ASIZE:0]   used;
    logic [ASIZE:0]   fcount;
    logic             overflow;

    pkt_fifo_sync #(
        .ASIZE      (ASIZE),
        .DSIZE      (DSIZE),
        .AFULL_LVL  (6),
        .AEMPTY_LVL (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wreq     (wreq),
        .wdata    (wdata),
        .wlast    (wlast),
        .wabort   (wabort),
        .rreq     (rreq),
        .rdata    (rdata),
        .rlast    (rlast),
        .rvalid   (rvalid),
        .full     (full),
        .empty    (empty),
        .afull    (afull),
        .aempty   (aempty),
        .used     (used),
        .fcount   (fcount),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: committed words, pending words, drop flag, frame count.
    logic [32:0] mq[$];
    logic [32:0] pq[$];
    logic [32:0] exp_q[$];
    bit          m_drop;
    int          m_fc;
    logic [31:0] e_rdata;
    logic        e_rlast;
    int          checks;
    int          failures;
    int          max_fc;

    typedef struct {
        logic        wq;
        logic [31:0] wd;
        logic        wl;
        logic        wa;
        logic        rq;
        int          e_used;
        logic        e_empty;
        int          e_fc;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input bit rd_ok, input bit e_ovf);
        int          m_used;
        logic [32:0] it;
        m_used = mq.size() + pq.size();
        chk("rvalid", int'(rvalid), int'(rd_ok));
        if (rvalid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_read", 1, 0);
            end else begin
                it      = exp_q.pop_front();
                e_rdata = it[31:0];
                e_rlast = it[32];
            end
        end
        chk("rdata", int'(rdata), int'(e_rdata));
        chk("rlast", int'(rlast), int'(e_rlast));
        chk("used", int'(used), m_used);
        chk("fcount", int'(fcount), m_fc);
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("full", int'(full), int'(m_used == DEPTH));
        chk("afull", int'(afull), int'(m_used >= 6));
        chk("aempty", int'(aempty), int'(mq.size() <= 2));
        chk("overflow", int'(overflow), int'(e_ovf));
        if (int'(fcount) > max_fc) max_fc = int'(fcount);
        $display("cyc t=%0t wreq=%0b wlast=%0b wabort=%0b rreq=%0b -> used=%0d fcount=%0d rvalid=%0b rdata=%0h rlast=%0b ovf=%0b",
                 $time, wreq, wlast, wabort, rreq, used, fcount, rvalid, rdata, rlast, overflow);
    endtask

    task automatic cyc(input logic wq, input logic [31:0] wd, input logic wl,
                       input logic wa, input logic rq);
        int          used_pre;
        bit          rd_ok;
        bit          e_ovf;
        logic [32:0] it;
        wreq = wq; wdata = wd; wlast = wl; wabort = wa; rreq = rq;
        used_pre = mq.size() + pq.size();
        rd_ok    = rq && (mq.size() > 0);
        e_ovf    = 1'b0;
        if (rd_ok) begin
            it = mq.pop_front();
            exp_q.push_back(it);
            if (it[32]) m_fc--;
        end
        if (wa) begin
            pq.delete();
            m_drop = 1'b0;
        end else if (wq) begin
            if (m_drop) begin
                if (wl) m_drop = 1'b0;
            end else if (used_pre == DEPTH) begin
                pq.delete();
                e_ovf  = 1'b1;
                m_drop = !wl;
            end else begin
                pq.push_back({wl, wd});
                if (wl) begin
                    foreach (pq[k]) mq.push_back(pq[k]);
                    pq.delete();
                    m_fc++;
                end
            end
        end
        @(posedge clk);
        #1;
        wreq = 1'b0; wlast = 1'b0; wabort = 1'b0; rreq = 1'b0;
        // Carry rd_ok into the compare of the cycle just completed.
        check_outputs(rd_ok, e_ovf);
    endtask

    task automatic reset_dut();
        wreq = 1'b0; wlast = 1'b0; wabort = 1'b0; rreq = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete(); pq.delete(); exp_q.delete();
        m_drop = 1'b0; m_fc = 0; e_rdata = '0; e_rlast = 1'b0;
        check_outputs(1'b0, 1'b0);
    endtask

    initial begin
        checks = 0; failures = 0; max_fc = 0;
        tbl[0]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 0, 1'b0};
        tbl[1]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, 2, 1'b1, 0, 1'b0};
        tbl[2]  = '{1'b1, 32'hA3, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1, 1'b0};
        tbl[3]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1, 1'b0};
        tbl[4]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1, 1'b0};
        tbl[5]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 0, 1'b1, 0, 1'b0};
        tbl[6]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 0, 1'b1, 0, 1'b0};
        tbl[7]  = '{1'b1, 32'hC1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 0, 1'b0};
        tbl[8]  = '{1'b1, 32'hC2, 1'b0, 1'b0, 1'b0, 2, 1'b1, 0, 1'b0};
        tbl[9]  = '{1'b1, 32'hC3, 1'b1, 1'b1, 1'b0, 0, 1'b1, 0, 1'b0};
        tbl[10] = '{1'b1, 32'hB1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1, 1'b0};
        tbl[11] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 0, 1'b1, 0, 1'b0};

        reset_dut();

        // Reset mid-frame with five uncommitted words.
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h10 + i, 1'b0, 1'b0, 1'b0);
        chk("t1_used_before_rst", int'(used), 5);
        reset_dut();
        chk("t1_used", int'(used), 0);
        chk("t1_fcount", int'(fcount), 0);
        chk("t1_empty", int'(empty), 1);
        chk("t1_rvalid", int'(rvalid), 0);

        // Table: commit, ordered read-back, empty read, abort, single-beat frame.
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].wq, tbl[i].wd, tbl[i].wl, tbl[i].wa, tbl[i].rq);
            chk("tbl_used", int'(used), tbl[i].e_used);
            chk("tbl_empty", int'(empty), int'(tbl[i].e_empty));
            chk("tbl_fcount", int'(fcount), tbl[i].e_fc);
            chk("tbl_ovf", int'(overflow), int'(tbl[i].e_ovf));
        end
        chk("tbl_last_rdata", int'(rdata), 32'hB1);

        // Second frame overflows and is dropped; first frame survives.
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h40 + i, i == 4, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h50 + i, 1'b0, 1'b0, 1'b0);
        chk("t4_full", int'(full), 1);
        cyc(1'b1, 32'h53, 1'b1, 1'b0, 1'b0);
        chk("t4_ovf", int'(overflow), 1);
        chk("t4_used", int'(used), 5);
        chk("t4_fcount", int'(fcount), 1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t4_ovf_pulse", int'(overflow), 0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("t4_empty", int'(empty), 1);

        // Full with simultaneous read and write: write rejected.
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h60 + i, (i % 4) == 3, 1'b0, 1'b0);
        chk("t5_full", int'(full), 1);
        cyc(1'b1, 32'h6F, 1'b1, 1'b0, 1'b1);
        chk("t5_ovf", int'(overflow), 1);
        chk("t5_used", int'(used), 7);
        chk("t5_rvalid", int'(rvalid), 1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Frame longer than DEPTH: dropped once, no re-pulse, FIFO keeps working.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'h70 + i, i == 9, 1'b0, 1'b0);
            if (i == 8) chk("long_ovf", int'(overflow), 1);
            if (i == 9) chk("long_no_repulse", int'(overflow), 0);
        end
        chk("long_used", int'(used), 0);
        cyc(1'b1, 32'hE1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("long_recover", int'(rdata), 32'hE1);

        // Single-beat frames across pointer wrap, with random reads.
        max_fc = 0;
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 32'hF00 + i, 1'b1, 1'b0, (i >= 10) && ($urandom_range(0, 1) == 1));
        for (int i = 0; i < 12; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (max_fc > DEPTH) begin
            failures++;
            $display("FAIL t6_fcount_max: got %0d expected <= %0d", max_fc, DEPTH);
        end
        chk("t6_drained", int'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
